// File: rtl/relu_backward_pkg.sv
// Shared constants, state encoding and the mask predicate for the ReLU backward unit.
package relu_backward_pkg;

    localparam int INTERNAL_BITS   = 16;
    localparam int RELU_MASK_DEPTH = 1024;

    typedef enum logic {
        RB_S_FWD = 1'b0,
        RB_S_BWD = 1'b1
    } rb_state_t;

    // Strict signed "> 0": sign bit clear and at least one bit set.
    function automatic logic is_positive(input logic [INTERNAL_BITS-1:0] v);
        return !v[INTERNAL_BITS-1] && (|v);
    endfunction

endpackage

// File: rtl/relu_mask_ram.sv
// DEPTH x 1 mask store: synchronous write, asynchronous read.
module relu_mask_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic          i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic          o_rdata
);

    logic r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/relu_backward.sv
// Records a positive-mask during the forward pass and replays it over the gradient stream.
module relu_backward
    import relu_backward_pkg::*;
#(
    parameter int DEPTH = RELU_MASK_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fwd_valid,
    input  logic [INTERNAL_BITS-1:0] fwd_data,
    input  logic                     fwd_last,
    output logic                     fwd_ready,
    input  logic                     bwd_in_valid,
    input  logic [INTERNAL_BITS-1:0] bwd_in_grad,
    output logic                     bwd_in_ready,
    output logic                     bwd_out_valid,
    output logic [INTERNAL_BITS-1:0] bwd_out_grad,
    output logic                     bwd_out_last,
    input  logic                     bwd_out_ready,
    output logic                     overflow
);

    rb_state_t                r_state;
    rb_state_t                w_state_next;
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [AW:0]              r_len;
    logic                     r_out_valid;
    logic [INTERNAL_BITS-1:0] r_out_grad;
    logic                     r_out_last;
    logic                     r_overflow;

    logic w_fwd_acc;
    logic w_bwd_acc;
    logic w_in_ready;
    logic w_wr_full;
    logic w_rd_last;
    logic w_fwd_end;
    logic w_mask_bit;

    assign w_in_ready = (r_state == RB_S_BWD) && (!r_out_valid || bwd_out_ready);
    assign w_fwd_acc  = fwd_valid && (r_state == RB_S_FWD);
    assign w_bwd_acc  = bwd_in_valid && w_in_ready;
    assign w_wr_full  = (r_wr_ptr == AW'(DEPTH - 1));
    assign w_rd_last  = ({1'b0, r_rd_ptr} == (r_len - (AW+1)'(1)));
    // The last slot of the mask closes the tensor even without fwd_last.
    assign w_fwd_end  = w_fwd_acc && (fwd_last || w_wr_full);

    relu_mask_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mask_ram (
        .clk     (clk),
        .i_we    (w_fwd_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (is_positive(fwd_data)),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mask_bit)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RB_S_FWD: if (w_fwd_end) w_state_next = RB_S_BWD;
            RB_S_BWD: if (w_bwd_acc && w_rd_last) w_state_next = RB_S_FWD;
            default:  w_state_next = RB_S_FWD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RB_S_FWD;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_len       <= '0;
            r_out_valid <= 1'b0;
            r_out_grad  <= '0;
            r_out_last  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_fwd_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_fwd_end) begin
                    r_len    <= {1'b0, r_wr_ptr} + (AW+1)'(1);
                    r_rd_ptr <= '0;
                end
                if (w_wr_full && !fwd_last) begin
                    r_overflow <= 1'b1;
                end
            end
            if (w_bwd_acc) begin
                r_out_grad  <= w_mask_bit ? bwd_in_grad : '0;
                r_out_last  <= w_rd_last;
                r_out_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                if (w_rd_last) begin
                    r_wr_ptr <= '0;
                end
            end else if (r_out_valid && bwd_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign fwd_ready     = (r_state == RB_S_FWD);
    assign bwd_in_ready  = w_in_ready;
    assign bwd_out_valid = r_out_valid;
    assign bwd_out_grad  = r_out_grad;
    assign bwd_out_last  = r_out_last;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_relu_backward.sv
// Scoreboard bench: two instances (large DEPTH and DEPTH=4), muxed onto one monitor by sel.
module tb_relu_backward;
    import relu_backward_pkg::*;

    localparam int W = INTERNAL_BITS;

    logic         clk = 1'b0;
    logic         reset;
    logic         sel;
    logic         fwd_valid, fwd_last, bwd_in_valid, bwd_out_ready;
    logic [W-1:0] fwd_data, bwd_in_grad;

    logic         a_fwd_ready, a_in_ready, a_out_valid, a_out_last, a_overflow;
    logic         b_fwd_ready, b_in_ready, b_out_valid, b_out_last, b_overflow;
    logic [W-1:0] a_out_grad, b_out_grad;

    logic         m_fwd_ready, m_in_ready, m_out_valid, m_out_last, m_overflow;
    logic [W-1:0] m_out_grad;

    typedef struct {
        int grad;
        bit last;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    relu_backward #(.DEPTH(16)) u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .fwd_valid     (fwd_valid && !sel),
        .fwd_data      (fwd_data),
        .fwd_last      (fwd_last),
        .fwd_ready     (a_fwd_ready),
        .bwd_in_valid  (bwd_in_valid && !sel),
        .bwd_in_grad   (bwd_in_grad),
        .bwd_in_ready  (a_in_ready),
        .bwd_out_valid (a_out_valid),
        .bwd_out_grad  (a_out_grad),
        .bwd_out_last  (a_out_last),
        .bwd_out_ready (bwd_out_ready),
        .overflow      (a_overflow)
    );

    relu_backward #(.DEPTH(4)) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .fwd_valid     (fwd_valid && sel),
        .fwd_data      (fwd_data),
        .fwd_last      (fwd_last),
        .fwd_ready     (b_fwd_ready),
        .bwd_in_valid  (bwd_in_valid && sel),
        .bwd_in_grad   (bwd_in_grad),
        .bwd_in_ready  (b_in_ready),
        .bwd_out_valid (b_out_valid),
        .bwd_out_grad  (b_out_grad),
        .bwd_out_last  (b_out_last),
        .bwd_out_ready (bwd_out_ready),
        .overflow      (b_overflow)
    );

    assign m_fwd_ready = sel ? b_fwd_ready : a_fwd_ready;
    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_out_valid = sel ? b_out_valid : a_out_valid;
    assign m_out_grad  = sel ? b_out_grad  : a_out_grad;
    assign m_out_last  = sel ? b_out_last  : a_out_last;
    assign m_overflow  = sel ? b_overflow  : a_overflow;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end else begin
            $display("[TB] ok   %s: %0d", name, act);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge whenever valid && ready here.
    always @(negedge clk) begin
        if (!reset && m_out_valid && bwd_out_ready) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_output: got %0d, expected none", int'($signed(m_out_grad)));
            end else begin
                e = q.pop_front();
                check("out_grad", int'($signed(m_out_grad)), e.grad);
                check("out_last", int'(m_out_last), int'(e.last));
            end
        end
    end

    task automatic send_fwd(input int d, input bit last);
        fwd_valid = 1'b1;
        fwd_data  = W'(d);
        fwd_last  = last;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_fwd_ready) begin
                @(posedge clk);
                #1;
                fwd_valid = 1'b0;
                fwd_last  = 1'b0;
                return;
            end
        end
        check("fwd_accept_timeout", 0, 1);
        fwd_valid = 1'b0;
        fwd_last  = 1'b0;
    endtask

    task automatic send_grad(input int g, input int exp_grad, input bit exp_last);
        exp_t x;
        bwd_in_valid = 1'b1;
        bwd_in_grad  = W'(g);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_in_ready) begin
                x.grad = exp_grad;
                x.last = exp_last;
                q.push_back(x);
                @(posedge clk);
                #1;
                bwd_in_valid = 1'b0;
                return;
            end
        end
        check("grad_accept_timeout", 0, 1);
        bwd_in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("drain_timeout", q.size(), 0);
        q.delete();
    endtask

    logic [W-1:0] held;

    initial begin
        reset = 1'b1; sel = 1'b0;
        fwd_valid = 1'b0; fwd_data = '0; fwd_last = 1'b0;
        bwd_in_valid = 1'b0; bwd_in_grad = '0; bwd_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_fwd_ready", int'(m_fwd_ready), 1);
        check("rst_in_ready", int'(m_in_ready), 0);
        check("rst_out_valid", int'(m_out_valid), 0);
        check("rst_out_grad", int'(m_out_grad), 0);
        check("rst_out_last", int'(m_out_last), 0);
        check("rst_overflow", int'(m_overflow), 0);

        // Basic mask
        send_fwd(5, 0); send_fwd(-3, 0); send_fwd(0, 0); send_fwd(7, 1);
        check("basic_fwd_ready_in_bwd", int'(m_fwd_ready), 0);
        send_grad(10, 10, 0); send_grad(11, 0, 0);
        send_grad(12, 0, 0);  send_grad(13, 13, 1);
        wait_drain();
        check("basic_back_to_fwd", int'(m_fwd_ready), 1);
        check("basic_overflow", int'(m_overflow), 0);

        // Backpressure: 3-cycle stall in the middle of an 8-gradient stream
        for (int i = 0; i < 8; i++) send_fwd(i + 1, i == 7);
        fork
            for (int i = 0; i < 8; i++) send_grad(100 + i, 100 + i, i == 7);
            begin
                repeat (3) @(posedge clk);
                #1 bwd_out_ready = 1'b0;
                held = m_out_grad;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("bp_valid_held", int'(m_out_valid), 1);
                    check("bp_grad_stable", int'(m_out_grad), int'(held));
                    check("bp_in_ready_low", int'(m_in_ready), 0);
                end
                @(posedge clk);
                #1 bwd_out_ready = 1'b1;
            end
        join
        wait_drain();

        // Overflow on the DEPTH=4 instance
        sel = 1'b1;
        send_fwd(3, 0); send_fwd(-3, 0); send_fwd(0, 0); send_fwd(8, 0);
        fwd_valid = 1'b1; fwd_data = W'(9);
        @(negedge clk);
        check("ovf_sample5_ready", int'(m_fwd_ready), 0);
        @(posedge clk); #1 fwd_data = W'(10);
        @(negedge clk);
        check("ovf_sample6_ready", int'(m_fwd_ready), 0);
        @(posedge clk); #1 fwd_valid = 1'b0;
        check("ovf_flag", int'(m_overflow), 1);
        send_grad(20, 20, 0); send_grad(21, 0, 0);
        send_grad(22, 0, 0);  send_grad(23, 23, 1);
        wait_drain();
        send_fwd(5, 1);
        send_grad(7, 7, 1);
        wait_drain();
        check("ovf_sticky", int'(m_overflow), 1);
        sel = 1'b0;

        // Boundary values
        send_fwd(-32768, 0); send_fwd(1, 0); send_fwd(32767, 1);
        send_grad(-1, 0, 0); send_grad(-1, -1, 0); send_grad(-1, -1, 1);
        wait_drain();

        // Reset while the second of four gradients sits unconsumed in the output register
        send_fwd(1, 0); send_fwd(2, 0); send_fwd(3, 0); send_fwd(4, 1);
        send_grad(50, 50, 0);
        wait_drain();
        send_grad(51, 51, 0);
        bwd_out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        bwd_out_ready = 1'b1;
        check("rstmid_out_valid", int'(m_out_valid), 0);
        check("rstmid_fwd_ready", int'(m_fwd_ready), 1);
        check("rstmid_overflow", int'(m_overflow), 0);
        check("rstmid_b_overflow", int'(b_overflow), 0);
        send_fwd(4, 1);
        send_grad(9, 9, 1);
        wait_drain();

        // Back-to-back tensors
        send_fwd(1, 0); send_fwd(-1, 1);
        send_grad(3, 3, 0); send_grad(3, 0, 1);
        check("b2b_fwd_ready_next", int'(m_fwd_ready), 1);
        send_fwd(-1, 0); send_fwd(1, 1);
        send_grad(3, 0, 0); send_grad(3, 3, 1);
        wait_drain();
        check("b2b_end_fwd_ready", int'(m_fwd_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/relu_backward.md
# relu_backward

Streaming backward-pass unit for the ReLU activation stage of the CNN datapath. During the forward pass it records a 1-bit "positive" mask for every pre-activation value presented to the ReLU. During the backward pass it replays that mask against the incoming gradient stream, passing gradients where the forward input was > 0 and emitting 0 elsewhere. It sits beside `Relu` on the forward path and on the gradient return path of the training datapath.

## Interface
- `DEPTH`, default 1024: maximum number of mask entries per tensor.
- `AW`, default `$clog2(DEPTH)`: pointer width.
- `W`, fixed at `` `INTERNAL_BITS `` from `def.v`: data and gradient width. This is not a parameter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `fwd_valid` in 1: forward pre-activation sample valid.
- `fwd_data` in W signed: forward pre-activation value, the same value the ReLU receives.
- `fwd_last` in 1: the current forward sample is the last of the tensor.
- `fwd_ready` out 1: block accepts a forward sample.
- `bwd_in_valid` in 1: incoming gradient valid.
- `bwd_in_grad` in W signed: gradient with respect to the ReLU output.
- `bwd_in_ready` out 1: block accepts a gradient.
- `bwd_out_valid` out 1: outgoing gradient valid.
- `bwd_out_grad` out W signed: gradient with respect to the ReLU input.
- `bwd_out_last` out 1: the outgoing gradient is the last of the tensor.
- `bwd_out_ready` in 1: downstream accepts the outgoing gradient.
- `overflow` out 1: sticky flag; the tensor exceeded `DEPTH`.

## Operation
- The FSM has two states, S_FWD and S_BWD. Reset enters S_FWD.
- **S_FWD**
  - `fwd_ready`=1 and `bwd_in_ready`=0.
  - On each accepted forward sample: `mask[wr_ptr] <= (fwd_data > 0)`, then `wr_ptr++`. The comparison is strict and signed, so 0 and negative values give mask 0.
  - If `fwd_last` is accepted: `len <= wr_ptr+1`, `rd_ptr <= 0`, and the FSM goes to S_BWD.
  - If the sample at `wr_ptr == DEPTH-1` is accepted without `fwd_last`, it is treated as last: `len=DEPTH`, `overflow <= 1`, and the FSM goes to S_BWD.
- **S_BWD**
  - `fwd_ready`=0.
  - `bwd_in_ready = !bwd_out_valid || bwd_out_ready`. The output register is a one-entry skid with no bubble under continuous flow.
  - On each accepted gradient:
    - `bwd_out_grad <= mask[rd_ptr] ? bwd_in_grad : 0`
    - `bwd_out_last <= (rd_ptr == len-1)`
    - `bwd_out_valid <= 1`
    - `rd_ptr++`
  - After accepting the gradient at `rd_ptr == len-1`, the FSM returns to S_FWD with `wr_ptr <= 0`. An output still pending in the register drains normally. A new forward sample may be accepted in the next cycle.
- **Output register:** when `bwd_out_valid && bwd_out_ready` and no new gradient is accepted in the same cycle, `bwd_out_valid <= 0`.
- **Holding:** `bwd_out_grad` and `bwd_out_last` are held stable while `bwd_out_valid && !bwd_out_ready`.
- **Overflow:** `overflow` clears only on `reset`.
- **Arithmetic:** no arithmetic on data; the gradient passes bit-exact or is forced to all-zero.

## Timing
- **Reset values:**
  - State S_FWD; `wr_ptr`, `rd_ptr`, `len` = 0.
  - `fwd_ready`=1, `bwd_in_ready`=0.
  - `bwd_out_valid`=0, `bwd_out_grad`=0, `bwd_out_last`=0.
  - `overflow`=0.
  - Mask contents are not cleared (don't-care).
- **Forward latency:** the mask bit is written on the acceptance edge. The write and the state change take effect on the same edge as `fwd_last` acceptance.
- **Backward latency:** 1 cycle from `bwd_in_valid && bwd_in_ready` to `bwd_out_valid`. Throughput is 1 gradient per cycle while `bwd_out_ready`=1.
- **Mask read:** combinational from `rd_ptr`.
- **Inputs outside their state:**
  - `fwd_valid` is ignored in S_BWD; no write occurs and `wr_ptr` is unchanged.
  - `bwd_in_valid` is ignored in S_FWD.
- **Reset mid-tensor:** any in-flight output is dropped (`bwd_out_valid`=0 the next cycle), pointers return to 0, and the FSM is in S_FWD.
- **Single-element tensor:** `fwd_last` on the first sample gives `len`=1. The first accepted gradient carries `bwd_out_last`=1, and the FSM returns to S_FWD on the following edge.

## Structure
- Add to `def.v`:
  - State encodings `` `RB_S_FWD `` = 1'b0 and `` `RB_S_BWD `` = 1'b1.
  - `` `RELU_MASK_DEPTH `` as the project default for `DEPTH`.
- Sub-module `relu_mask_ram`: a `DEPTH`×1 register array with a synchronous write port and an asynchronous read port. It keeps storage separate from the FSM/handshake logic in `relu_backward`.

## Test plan
- **Basic mask:** forward {5, -3, 0, 7} with last on 7, then gradients {10, 11, 12, 13}. Required: out {10, 0, 0, 13}, `bwd_out_last` only on 13, FSM back in S_FWD, `overflow`=0.
- **Backpressure:** 8-element tensor, all inputs positive. Hold `bwd_out_ready`=0 for 3 cycles mid-stream. Required: `bwd_out_grad` stable, `bwd_in_ready`=0 while stalled, no loss or duplication, and the order is preserved.
- **Overflow:** with `DEPTH`=4, send 6 forward samples without last. Required:
  - Samples 5 and 6 see `fwd_ready`=0.
  - `len`=4 and `overflow`=1.
  - The 4th gradient has last=1.
  - `overflow` stays 1 through the next tensor.
- **Boundary values:** forward {-2^(W-1), 1, 2^(W-1)-1} with gradient -1 everywhere. Required: out {0, -1, -1}.
- **Reset mid-backward:** assert `reset` after 2 of 4 gradients. Required:
  - Next cycle: `bwd_out_valid`=0, `fwd_ready`=1, `overflow`=0.
  - A following 1-element tensor {4}, gradient 9, yields out 9 with last=1.
- **Back-to-back tensors:** tensor A = {1, -1}, then tensor B = {-1, 1}, with gradient 3 everywhere. Required: outputs {3, 0} then {0, 3}. A new forward sample must be accepted the cycle after A's last gradient is accepted.
